// File: rtl/simple_computer.sv
// simple_computer: single-cycle 32-bit CPU fetching from a flat code vector.
// Define COMPUTER_MULDIV_EN to build the MUL/DIV R-type functions.
module simple_computer #(
  parameter int CODE_WORDS = 2048,
  parameter int PC_W       = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [32*CODE_WORDS-1:0] code,
  output logic [PC_W-1:0]         pc,
  output logic                    halted,
  output logic                    wb_en,
  output logic [4:0]              wb_addr,
  output logic [31:0]             wb_data
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d, wb_en_q, wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [31:0]     regs_q [32];
  logic [31:0]     instr, a, b, sext, zext, br, wd;
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, sh, wa;
  logic            we;
  always_comb begin
    instr = code[{pc_q, 5'd0} +: 32];
    op = instr[31:26];
    rs = instr[25:21];
    rt = instr[20:16];
    rd = instr[15:11];
    sh = instr[10:6];
    funct = instr[5:0];
    a = regs_q[rs];
    b = regs_q[rt];
    sext = {{16{instr[15]}}, instr[15:0]};
    zext = {16'd0, instr[15:0]};
    br = 32'(pc_q) + 32'd1 + sext;
    pc_d = pc_q + PC_W'(1);
    halted_d = halted_q;
    we = 1'b0;
    wa = rd;
    wd = '0;
    case (op)
      6'h00: if (instr == '0) begin
        halted_d = 1'b1;
        pc_d = pc_q;
      end
      6'h01: begin
        we = 1'b1;
        case (funct)
          6'h00: wd = a + b;
          6'h01: wd = a - b;
`ifdef COMPUTER_MULDIV_EN
          6'h02: wd = a * b;
          6'h03: wd = (b == '0) ? '1 : a / b;
`endif
          6'h04: wd = a & b;
          6'h05: wd = a | b;
          6'h06: wd = a ^ b;
          6'h07: wd = b << sh;
          6'h08: wd = b >> sh;
          default: we = 1'b0;
        endcase
      end
      6'h09: begin we = 1'b1; wa = rt; wd = a + sext; end
      6'h0C: begin we = 1'b1; wa = rt; wd = a & zext; end
      6'h0D: begin we = 1'b1; wa = rt; wd = a | zext; end
      6'h04: if (a == b) pc_d = br[PC_W-1:0];
      6'h02: pc_d = instr[PC_W-1:0];
      default: ;
    endcase
    // r0 is hardwired: a write to it is dropped and leaves wb_addr/wb_data alone
    wb_en_d = we && wa != 5'd0;
    wb_addr_d = wb_en_d ? wa : wb_addr_q;
    wb_data_d = wb_en_d ? wd : wb_data_q;
    if (halted_q) begin
      pc_d = pc_q;
      wb_en_d = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      halted_q <= 1'b0;
      wb_en_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      halted_q <= halted_d;
      wb_en_q <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      if (wb_en_d) regs_q[wb_addr_d] <= wb_data_d;
    end
  end
  assign pc = pc_q;
  assign halted = halted_q;
  assign wb_en = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
endmodule

// File: tb/tb_simple_computer.sv
// tb_simple_computer: ISA-level reference model plus directed and random programs.
module tb_simple_computer;
  localparam int CW = 2048;
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [32*CW-1:0] code = '0;
  logic [10:0]      pc;
  logic             halted, wb_en;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  int n_cmp = 0, n_bad = 0;
  bit cmp_on = 1'b0;
  simple_computer #(.CODE_WORDS(CW), .PC_W(11)) dut (
    .clk(clk), .reset(reset), .code(code), .pc(pc), .halted(halted),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int f);
    return {6'd1, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(f)};
  endfunction
  // Architectural model: one instruction per edge, straight from the ISA rules.
  logic [31:0] m_r [32];
  logic [31:0] m_pc, m_wbdata;
  logic        m_halt, m_wben;
  logic [4:0]  m_wbaddr;
  always @(posedge clk or negedge reset) begin
    logic [31:0] w, ra, rb, val;
    int dst, sx, nxt;
    if (!reset) begin
      m_pc = 0; m_halt = 0; m_wben = 0; m_wbaddr = 0; m_wbdata = 0;
      foreach (m_r[i]) m_r[i] = 0;
    end else if (m_halt) begin
      m_wben = 0;
    end else begin
      w = code[m_pc*32 +: 32];
      ra = m_r[w[25:21]];
      rb = m_r[w[20:16]];
      sx = $signed(w[15:0]);
      dst = -1;
      val = 0;
      nxt = (int'(m_pc) + 1) % CW;
      case (w[31:26])
        6'h00: if (w == 0) begin m_halt = 1; nxt = int'(m_pc); end
        6'h01: begin
          dst = int'(w[15:11]);
          case (w[5:0])
            0: val = ra + rb;
            1: val = ra - rb;
`ifdef COMPUTER_MULDIV_EN
            2: val = ra * rb;
            3: val = (rb == 0) ? 32'hFFFF_FFFF : ra / rb;
`endif
            4: val = ra & rb;
            5: val = ra | rb;
            6: val = ra ^ rb;
            7: val = rb << w[10:6];
            8: val = rb >> w[10:6];
            default: dst = -1;
          endcase
        end
        6'h09: begin dst = int'(w[20:16]); val = ra + sx; end
        6'h0C: begin dst = int'(w[20:16]); val = ra & {16'd0, w[15:0]}; end
        6'h0D: begin dst = int'(w[20:16]); val = ra | {16'd0, w[15:0]}; end
        6'h04: if (ra == rb) nxt = (int'(m_pc) + 1 + sx) & (CW - 1);
        6'h02: nxt = int'(w) % CW;
        default: ;
      endcase
      if (dst > 0) begin
        m_r[dst] = val; m_wben = 1; m_wbaddr = 5'(dst); m_wbdata = val;
      end else m_wben = 0;
      m_pc = 32'(nxt);
    end
  end
  always @(negedge clk) if (cmp_on) begin
    chk("pc", 32'(pc), m_pc);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("wb_en", 32'(wb_en), 32'(m_wben));
    chk("wb_addr", 32'(wb_addr), 32'(m_wbaddr));
    chk("wb_data", wb_data, m_wbdata);
  end
  task automatic setw(input int k, input logic [31:0] w);
    code[k*32 +: 32] = w;
  endtask
  task automatic enter_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    code = '0;
  endtask
  task automatic leave_reset();
    @(negedge clk);
    #2 reset = 1'b1;
  endtask
  task automatic edge_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [31:0] rand_word();
    int r1 = $urandom_range(0, 7), r2 = $urandom_range(0, 7), r3 = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0, 8: return enc_r(r1, r2, r3, $urandom_range(0, 31), $urandom_range(0, 10));
      1, 9: return enc_i(9, r1, r2, 16'($urandom));
      2: return enc_i(12, r1, r2, 16'($urandom));
      3: return enc_i(13, r1, r2, 16'($urandom));
      4: return enc_i(4, r1, r2, 16'($signed($urandom_range(0, 16)) - 8));
      5: return {6'h02, 26'($urandom)};
      6: return 32'($urandom_range(1, 255));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    for (int k = 0; k < CW; k++) setw(k, $urandom);
    edge_n(3);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_wb_en", 32'(wb_en), 0);
    cmp_on = 1'b1;
    // ADDI r1,r0,15 ; DIV r21 = r1/r2 (r2 = 0) ; HALT
    enter_reset();
    setw(0, 32'h2401000F);
    setw(1, 32'h0422AF43);
    leave_reset();
    edge_n(1);
    chk("e1_wb_en", 32'(wb_en), 1);
    chk("e1_wb_addr", 32'(wb_addr), 1);
    chk("e1_wb_data", wb_data, 32'h0000000F);
    edge_n(1);
`ifdef COMPUTER_MULDIV_EN
    chk("e2_wb_en", 32'(wb_en), 1);
    chk("e2_wb_addr", 32'(wb_addr), 21);
    chk("e2_wb_data", wb_data, 32'hFFFFFFFF);
`else
    chk("e2_wb_en", 32'(wb_en), 0);
`endif
    edge_n(1);
    chk("e3_halted", 32'(halted), 1);
    chk("e3_pc", 32'(pc), 2);
    edge_n(5);
    chk("frozen_pc", 32'(pc), 2);
    chk("frozen_wb_en", 32'(wb_en), 0);
    // wraparound add, r0 write discard, r0 read, branch to self
    enter_reset();
    setw(0, enc_i(9, 0, 1, 16'hFFFF));
    setw(1, enc_i(9, 0, 2, 16'h0001));
    setw(2, enc_r(1, 2, 3, 0, 0));
    setw(3, enc_i(9, 0, 0, 16'h0005));
    setw(4, enc_i(9, 0, 6, 16'h0007));
    setw(5, enc_i(4, 0, 0, 16'hFFFF));
    leave_reset();
    edge_n(1);
    chk("addi_m1", wb_data, 32'hFFFFFFFF);
    edge_n(2);
    chk("add_wrap_addr", 32'(wb_addr), 3);
    chk("add_wrap_data", wb_data, 32'h00000000);
    edge_n(1);
    chk("r0_wr_en", 32'(wb_en), 0);
    edge_n(1);
    chk("r0_read", wb_data, 32'h00000007);
    edge_n(2);
    chk("beq_self_pc", 32'(pc), 5);
    // J 5 then branch-to-self
    enter_reset();
    setw(0, {6'h02, 26'd5});
    setw(5, enc_i(4, 0, 0, 16'hFFFF));
    leave_reset();
    edge_n(1);
    chk("jump_pc", 32'(pc), 5);
    edge_n(3);
    chk("jump_hold_pc", 32'(pc), 5);
    // all-NOP program: pc walks the whole space and wraps
    enter_reset();
    for (int k = 0; k < CW; k++) setw(k, 32'h00000001);
    leave_reset();
    edge_n(CW - 1);
    chk("nop_pc_2047", 32'(pc), 2047);
    edge_n(1);
    chk("nop_pc_wrap", 32'(pc), 0);
    chk("nop_not_halted", 32'(halted), 0);
    // random programs, one with a reset dropped in mid-run
    for (int p = 0; p < 4; p++) begin
      enter_reset();
      for (int k = 0; k < CW; k++) setw(k, rand_word());
      leave_reset();
      edge_n(200);
      if (p == 1) begin
        #2 reset = 1'b0;
        #1;
        chk("async_pc", 32'(pc), 0);
        chk("async_halted", 32'(halted), 0);
        chk("async_wb_en", 32'(wb_en), 0);
        chk("async_wb_addr", 32'(wb_addr), 0);
        chk("async_wb_data", wb_data, 0);
        leave_reset();
      end
      edge_n(200);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/simple_computer.md
Name: simple_computer

Overview:
- Single-cycle 32-bit load/store-free CPU that executes a program supplied as a flat instruction vector.
- Contents: 32x32 register file, ALU (add/sub/logic/shift/mul/div) and program counter.
- One instruction executes per clock.
- Top of the processor hierarchy. Program words are fetched directly from the `code` input, with no RAM in the fetch path.

Parameters:
- CODE_WORDS, 2048: number of 32-bit instruction words in `code`.
- PC_W, 11: program-counter width in bits; must satisfy 2**PC_W == CODE_WORDS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 holds the CPU in reset; reset=1 runs.
- code  input  32*CODE_WORDS  program image; word k = code[32k+31:32k], so word 0 sits at the LSBs.
- pc  output  PC_W  current instruction word index.
- halted  output  1  set after a HALT instruction executes.
- wb_en  output  1  registered; 1 for the cycle after a register write.
- wb_addr  output  5  registered destination of the last write.
- wb_data  output  32  registered value of the last write.

Behaviour:
- Reset (async, reset=0): pc=0, r0..r31=0, halted=0, wb_en=0, wb_addr=0, wb_data=0. Reset takes effect immediately regardless of clk; it may be asserted mid-program.
- Each rising edge with reset=1 and halted=0:
  - fetch instr = code word[pc], decode, execute;
  - write the destination register, update wb_* and pc.
  - wb_en=0 on edges with no write.
- halted=1: pc, registers and wb_* freeze; wb_en=0.
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
  - sext(imm) = sign-extended imm; zext(imm) = zero-extended imm.
- r0 reads as 0 always; writes to r0 are discarded and give wb_en=0.
- Arithmetic is 32-bit, wraps modulo 2^32, and sets no flags.
- op 0x00, whole word 0x00000000: HALT. Sets halted=1; pc unchanged.
- op 0x00, any other word: NOP.
- op 0x01 R-type, rd = f(rs, rt) by funct:
  - 0x00 ADD, 0x01 SUB (rs-rt).
  - 0x02 MUL: low 32 bits of the unsigned product.
  - 0x03 DIV: unsigned rs/rt; rt=0 gives 0xFFFFFFFF.
  - 0x04 AND, 0x05 OR, 0x06 XOR.
  - 0x07 SLL rt by shamt, 0x08 SRL (logical) rt by shamt.
  - Any other funct: NOP.
- op 0x09 ADDI: rt = rs + sext(imm).
- op 0x0C ANDI: rt = rs & zext(imm).
- op 0x0D ORI: rt = rs | zext(imm).
- op 0x04 BEQ: if rs==rt then pc = pc+1+sext(imm), truncated to PC_W; else pc+1.
- op 0x02 J: pc = instr[PC_W-1:0].
- Any other op: NOP.
- Sequential pc = pc+1 modulo CODE_WORDS: 2047 wraps to 0.
- Operands are read before the write within a cycle, so an instruction with the same register as source and destination sees the old value.

Optional Feature:
- Macro: COMPUTER_MULDIV_EN.
- Defined: funct 0x02 (MUL) and 0x03 (DIV) operate as specified above.
- Undefined: no multiplier or divider is built; funct 0x02/0x03 act as NOP (no write, wb_en=0).

Test Plan:
- Hold reset=0, pulse clk, inject garbage into code -> pc=0, halted=0, wb_en=0. Then assert reset=0 mid-run -> outputs clear without a clock edge.
- Program word0=0x2401000F, word1=0x0422AF43, rest 0; release reset:
  - edge 1 -> wb r1=0x0000000F;
  - edge 2 -> wb r21=0xFFFFFFFF (divide by zero; with COMPUTER_MULDIV_EN);
  - edge 3 -> halted=1, pc=2, then frozen.
- Without COMPUTER_MULDIV_EN, same program -> edge 2 gives wb_en=0; halt at pc=2.
- ADDI r1=-1 (imm 0xFFFF), ADDI r2=1, R-ADD r3=r1+r2 -> r3=0x00000000 (wrap). ADDI to r0 -> wb_en=0 and r0 still reads 0.
- BEQ r0,r0 with imm=0xFFFF -> pc stays fixed (branch to self). J 5 -> pc=5.
- Program all NOPs (0x00000001) -> pc counts to 2047 then wraps to 0; halted stays 0.
